smoldvi_rx_gearbox: RTL and testbench

Receive-side TMDS deserialiser for one DVI lane. It assembles a narrow per-cycle bit stream from the lane deserialiser into TMDS symbols, one word every `W_OUT/W_IN` cycles. A bit-slip window aligns symbol boundaries. An aligner FSM hunts for TMDS control tokens during blanking and asserts `locked` once symbol alignment is proven; downstream TMDS decoders consume `dout` on `dout_valid`.

---
 rtl/smoldvi_pkg.sv | 23 ++
 rtl/smoldvi_rx_aligner.sv | 121 ++++++++++++
 rtl/smoldvi_rx_gearbox.sv | 101 ++++++++++
 tb/tb_smoldvi_rx_gearbox.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/smoldvi_pkg.sv
// Shared TMDS definitions for the smoldvi transmit and receive paths.
package smoldvi_pkg;

  localparam int TMDS_W = 10;

  // Control-period symbols, indexed by {c1, c0}.
  localparam logic [TMDS_W-1:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    ALIGN_HUNT   = 2'd0,
    ALIGN_CHECK  = 2'd1,
    ALIGN_LOCKED = 2'd2
  } align_state_e;

  function automatic logic is_ctrl_token(input logic [TMDS_W-1:0] sym);
    return (sym == TMDS_CTRL_00) || (sym == TMDS_CTRL_01) ||
           (sym == TMDS_CTRL_10) || (sym == TMDS_CTRL_11);
  endfunction

endpackage

// File: rtl/smoldvi_rx_aligner.sv
// Symbol aligner: hunts for runs of TMDS control tokens during blanking,
// requests bit slips while misaligned and reports lock once proven.
module smoldvi_rx_aligner
  import smoldvi_pkg::*;
#(
  parameter int W_OUT      = 10,
  parameter int LOCK_COUNT = 16,
  parameter int SLIP_WAIT  = 2048,
  parameter int LOSS_WAIT  = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_OUT-1:0] sym,
  input  logic             sym_valid,
  input  logic             auto_en,
  output logic             slip,
  output logic             locked
);

  localparam int WAIT_MAX = (SLIP_WAIT > LOSS_WAIT) ? SLIP_WAIT : LOSS_WAIT;
  localparam int WCNT_W   = $clog2(WAIT_MAX + 1);
  localparam int TCNT_W   = $clog2(LOCK_COUNT + 1);

  localparam logic [WCNT_W-1:0] SLIP_LIM = WCNT_W'(SLIP_WAIT);
  localparam logic [WCNT_W-1:0] LOSS_LIM = WCNT_W'(LOSS_WAIT);
  localparam logic [TCNT_W-1:0] LOCK_LIM = TCNT_W'(LOCK_COUNT);

  align_state_e      state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic              locked_q, locked_d;
  logic              slip_req;
  logic              is_tok;

  assign is_tok   = is_ctrl_token(TMDS_W'(sym));
  assign wcnt_inc = wcnt_q + 1'b1;
  assign tcnt_inc = tcnt_q + 1'b1;

  // Next-state logic; slips are decided combinationally so the offset moves
  // on the same edge that evaluates the word.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    slip_req = 1'b0;
    if (!auto_en) begin
      state_d = ALIGN_HUNT;
      wcnt_d  = '0;
      tcnt_d  = '0;
    end else if (sym_valid) begin
      case (state_q)
        ALIGN_HUNT: begin
          if (is_tok) begin
            state_d = ALIGN_CHECK;
            tcnt_d  = TCNT_W'(1);
            wcnt_d  = '0;
          end else if (wcnt_inc == SLIP_LIM) begin
            slip_req = 1'b1;
            wcnt_d   = '0;
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
        ALIGN_CHECK: begin
          if (is_tok) begin
            if (tcnt_inc == LOCK_LIM) begin
              state_d = ALIGN_LOCKED;
              wcnt_d  = '0;
              tcnt_d  = '0;
            end else begin
              tcnt_d = tcnt_inc;
            end
          end else begin
            // A lone token was a coincidence; move on to the next offset.
            slip_req = 1'b1;
            state_d  = ALIGN_HUNT;
            wcnt_d   = '0;
            tcnt_d   = '0;
          end
        end
        ALIGN_LOCKED: begin
          if (is_tok) begin
            wcnt_d = '0;
          end else if (wcnt_inc == LOSS_LIM) begin
            // Long active periods are normal; only drop lock, keep offset.
            state_d = ALIGN_HUNT;
            wcnt_d  = '0;
            tcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
        default: begin
          state_d = ALIGN_HUNT;
          wcnt_d  = '0;
          tcnt_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == ALIGN_LOCKED);
  end

  // Aligner state, counters and registered lock flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALIGN_HUNT;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      locked_q <= locked_d;
    end
  end

  assign slip   = slip_req;
  assign locked = locked_q;

endmodule

// File: rtl/smoldvi_rx_gearbox.sv
// One-lane TMDS receive gearbox: packs W_IN-bit beats into W_OUT-bit symbols
// through a bit-slip window, with an aligner that finds symbol boundaries.
module smoldvi_rx_gearbox
  import smoldvi_pkg::*;
#(
  parameter int W_IN       = 2,
  parameter int W_OUT      = 10,
  parameter int LOCK_COUNT = 16,
  parameter int SLIP_WAIT  = 2048,
  parameter int LOSS_WAIT  = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W_IN-1:0]            din,
  input  logic                       auto_en,
  input  logic                       bitslip,
  output logic [W_OUT-1:0]           dout,
  output logic                       dout_valid,
  output logic                       locked,
  output logic [$clog2(W_OUT)-1:0]   offset
);

  localparam int N      = W_OUT / W_IN;
  localparam int PH_W   = (N > 1) ? $clog2(N) : 1;
  localparam int OFS_W  = $clog2(W_OUT);
  localparam int SREG_W = 2 * W_OUT;
  localparam int BASE_W = $clog2(SREG_W);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(N - 1);
  localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(W_OUT - 1);

  logic [SREG_W-1:0] sreg_q, sreg_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [OFS_W-1:0]  offset_q, offset_d;
  logic [W_OUT-1:0]  dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [BASE_W-1:0] win_base;
  logic [W_OUT-1:0]  win;
  logic              align_slip;
  logic              slip;

  // Newest bits enter at the MSB so the oldest bit of the window lands in
  // dout[0]; the window reads the post-shift value to avoid a pipeline stage.
  assign sreg_d   = {din, sreg_q[SREG_W-1:W_IN]};
  assign win_base = BASE_W'(W_OUT) - BASE_W'(offset_q);
  assign win      = sreg_d[win_base +: W_OUT];

  assign slip = auto_en ? align_slip : bitslip;

  // Phase, word capture and offset update.
  always_comb begin
    phase_d      = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (phase_q == PH_LAST) begin
      dout_d       = win;
      dout_valid_d = 1'b1;
    end
    offset_d = offset_q;
    if (slip) begin
      offset_d = (offset_q == OFS_LAST) ? '0 : offset_q + 1'b1;
    end
  end

  // Datapath registers; reset discards any partially assembled word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q       <= '0;
      phase_q      <= '0;
      offset_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      phase_q      <= phase_d;
      offset_q     <= offset_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  smoldvi_rx_aligner #(
    .W_OUT      (W_OUT),
    .LOCK_COUNT (LOCK_COUNT),
    .SLIP_WAIT  (SLIP_WAIT),
    .LOSS_WAIT  (LOSS_WAIT)
  ) u_aligner (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym       (dout_q),
    .sym_valid (dout_valid_q),
    .auto_en   (auto_en),
    .slip      (align_slip),
    .locked    (locked)
  );

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign offset     = offset_q;

endmodule

// File: tb/tb_smoldvi_rx_gearbox.sv
// Directed bench for smoldvi_rx_gearbox: capture, manual/auto slip, lock,
// lock loss, false-token rejection, reset and offset wrap.
module tb_smoldvi_rx_gearbox;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [1:0] din     = '0;
  logic       auto_en = 1'b0;
  logic       bitslip = 1'b0;
  logic [9:0] dout;
  logic       dout_valid;
  logic       locked;
  logic [3:0] offset;

  int total = 0;
  int bad   = 0;

  int   cyc_n, strobes, lock_rise_at, lock_fall_at, lock_rises, slip_req;
  logic [3:0] fall_offset, offset_prev;
  logic locked_prev;
  int   strobe_cyc[$];
  int   slip_at[$];
  bit   bitq[$];

  localparam logic [9:0] TOK  = 10'h354;
  localparam logic [9:0] DATA = 10'h2CC;
  // Repeating 0x354 seen one bit older: dout[0] is the previous word's bit 9.
  localparam logic [9:0] TOK_ROT1 = 10'h2A9;
  // Same stream seen three bits older.
  localparam logic [9:0] TOK_ROT3 = 10'h2A6;

  always #5 clk = ~clk;

  smoldvi_rx_gearbox #(
    .W_IN       (2),
    .W_OUT      (10),
    .LOCK_COUNT (16),
    .SLIP_WAIT  (8),
    .LOSS_WAIT  (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .auto_en    (auto_en),
    .bitslip    (bitslip),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .offset     (offset)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int slip_n(input int i);
    if (i < slip_at.size()) return slip_at[i];
    return -1;
  endfunction

  task automatic clear_log();
    cyc_n        = 0;
    strobes      = 0;
    lock_rise_at = -1;
    lock_fall_at = -1;
    lock_rises   = 0;
    slip_req     = 0;
    fall_offset  = '0;
    offset_prev  = '0;
    locked_prev  = 1'b0;
    strobe_cyc.delete();
    slip_at.delete();
    bitq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    clear_log();
    rst_n = 1'b1;
  endtask

  // One clock: drive a beat, take the edge, then log events seen after it.
  task automatic cyc(input logic [1:0] d);
    din     = d;
    bitslip = (slip_req > 0);
    if (slip_req > 0) slip_req--;
    @(posedge clk);
    #1;
    bitslip = 1'b0;
    cyc_n++;
    if (dout_valid) begin
      strobes++;
      strobe_cyc.push_back(cyc_n);
    end
    if (locked && !locked_prev) begin
      lock_rises++;
      if (lock_rise_at < 0) lock_rise_at = strobes;
    end
    if (!locked && locked_prev) begin
      lock_fall_at = strobes;
      fall_offset  = offset;
    end
    if (offset != offset_prev) slip_at.push_back(strobes);
    locked_prev = locked;
    offset_prev = offset;
  endtask

  task automatic send_word(input logic [9:0] w);
    logic [1:0] d;
    for (int i = 0; i < 10; i++) bitq.push_back(w[i]);
    while (bitq.size() >= 2) begin
      d[0] = bitq.pop_front();
      d[1] = bitq.pop_front();
      cyc(d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_log();
    do_reset();
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_offset", offset, 0);

    // 1: aligned capture, manual mode
    auto_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_word(TOK);
      chk("t1_valid", dout_valid, 1);
      chk("t1_dout", dout, TOK);
    end
    chk("t1_first_strobe_cyc", strobe_cyc[0], 5);
    chk("t1_second_strobe_cyc", strobe_cyc[1], 10);
    chk("t1_strobes", strobes, 4);
    chk("t1_offset", offset, 0);

    // 2: manual slip, then two back-to-back pulses
    slip_req = 1;
    send_word(TOK);
    chk("t2_offset1", offset, 1);
    chk("t2_dout_rot1", dout, TOK_ROT1);
    send_word(TOK);
    chk("t2_dout_rot1b", dout, TOK_ROT1);
    slip_req = 2;
    send_word(TOK);
    chk("t2_offset3", offset, 3);
    chk("t2_dout_rot3", dout, TOK_ROT3);

    // 6: asynchronous reset mid-word, then ten manual slips wrap the offset
    cyc(2'b00);
    cyc(2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_dout", dout, 0);
    chk("t6_async_valid", dout_valid, 0);
    chk("t6_async_offset", offset, 0);
    chk("t6_async_locked", locked, 0);
    @(posedge clk);
    #3;
    clear_log();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      slip_req = 1;
      send_word(TOK);
      chk("t6_wrap_offset", offset, (i + 1) % 10);
    end
    for (int i = 0; i < 2; i++) begin
      send_word(TOK);
      chk("t6_dout_after_wrap", dout, TOK);
    end

    // 3: auto lock from a stream whose word boundary is 3 bits older
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 7; i++) bitq.push_back(1'b0);
    for (int i = 0; i < 45; i++) send_word(TOK);
    chk("t3_slip_count", slip_at.size(), 3);
    chk("t3_slip0_strobe", slip_n(0), 8);
    chk("t3_slip1_strobe", slip_n(1), 16);
    chk("t3_slip2_strobe", slip_n(2), 24);
    chk("t3_offset", offset, 3);
    chk("t3_lock_rise_strobe", lock_rise_at, 40);
    chk("t3_locked", locked, 1);
    chk("t3_dout", dout, TOK);

    // 5: 32 non-token words drop lock without slipping
    for (int i = 0; i < 35; i++) send_word(DATA);
    chk("t5_lock_fall_strobe", lock_fall_at, 78);
    chk("t5_fall_offset", fall_offset, 3);
    chk("t5_locked", locked, 0);
    chk("t5_slip_count", slip_at.size(), 3);
    chk("t5_dout", dout, DATA);

    // 4: a single token then a data word in CHECK forces a slip
    send_word(TOK);
    for (int i = 0; i < 3; i++) send_word(DATA);
    chk("t4_slip_count", slip_at.size(), 4);
    chk("t4_slip_strobe", slip_n(3), 83);
    chk("t4_offset", offset, 4);
    chk("t4_locked", locked, 0);
    chk("t4_lock_rises", lock_rises, 1);

    // bitslip has no effect while the aligner owns the offset
    slip_req = 1;
    send_word(DATA);
    chk("auto_ignores_bitslip", offset, 4);
    chk("auto_ignores_bitslip_cnt", slip_at.size(), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
